// File: rtl/serial_tx_if.sv
// Writer-side bus of the serial transmitter: byte push strobe plus status and line output.
// Latency: none, signal bundle only.
// Backpressure: writer watches full; pushes made while full are dropped by the transmitter.
interface serial_tx_if;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       busy;
  logic       tx;

  modport master (
    output wr_en,
    output wr_data,
    input  full,
    input  busy,
    input  tx
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    output full,
    output busy,
    output tx
  );
endinterface

// File: rtl/serial_tx.sv
// Buffered 8N1 serial transmitter: FIFO of bytes sent idle-high, LSB first at CLKRATE/BAUDRATE.
// Latency: write at edge N -> start bit on tx after edge N+1; each bit lasts DIVISOR clocks.
// Backpressure: full when DEPTH bytes wait; writes while full are discarded, no state change.
module serial_tx #(
  parameter int CLKRATE  = 3_579_545,
  parameter int BAUDRATE = 9600,
  parameter int DEPTH    = 4            // power of two, >= 2
) (
  input  logic       clk,
  input  logic       rst_n,
  serial_tx_if.slave bus
);

  // Clocks per bit; must come out at least 2.
  localparam int DIVISOR = CLKRATE / BAUDRATE;
  localparam int CNT_W   = $clog2(DIVISOR);
  localparam int PTR_W   = $clog2(DEPTH);

  typedef logic [CNT_W-1:0] bcnt_t;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   count_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam bcnt_t  BIT_LAST   = bcnt_t'(DIVISOR - 1);
  localparam count_t COUNT_FULL = count_t'(DEPTH);
  localparam count_t COUNT_ONE  = count_t'(1);
  localparam ptr_t   PTR_ONE    = ptr_t'(1);
  localparam bcnt_t  BCNT_ONE   = bcnt_t'(1);

  // FIFO state
  logic [7:0] mem [DEPTH];
  ptr_t       wr_ptr;
  ptr_t       rd_ptr;
  count_t     count;
  count_t     count_nxt;
  logic       full_q;

  // Framer state
  state_t     state;
  bcnt_t      bit_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift;
  logic       tx_q;

  logic       fifo_nempty;
  logic       bit_end;
  logic       push;
  logic       pop;

  assign fifo_nempty = (count != '0);
  assign bit_end     = (bit_cnt == BIT_LAST);
  // A write is refused on full even if a pop frees a slot in the same cycle.
  assign push        = bus.wr_en & ~full_q;
  // Head is taken when idle, or on the last stop-bit clock so frames run back to back.
  assign pop         = fifo_nempty & ((state == IDLE) | ((state == STOP) & bit_end));

  // Next occupancy; simultaneous push and pop cancel out.
  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + COUNT_ONE;
    end else if (!push && pop) begin
      count_nxt = count - COUNT_ONE;
    end
  end

  // Byte storage; contents are meaningless once the pointers are reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  // FIFO pointers, occupancy and the registered full flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count  <= count_nxt;
      full_q <= (count_nxt == COUNT_FULL);
    end
  end

  // Frame sequencer; tx is registered and updated on the same edge as each bit boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx_q    <= 1'b1;
          bit_cnt <= '0;
          if (pop) begin
            shift <= mem[rd_ptr];
            tx_q  <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (bit_end) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            tx_q    <= shift[0];
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt + BCNT_ONE;
          end
        end
        DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx_q  <= 1'b1;
              state <= STOP;
            end else begin
              shift   <= {1'b0, shift[7:1]};
              bit_idx <= bit_idx + 3'd1;
              tx_q    <= shift[1];
            end
          end else begin
            bit_cnt <= bit_cnt + BCNT_ONE;
          end
        end
        STOP: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (pop) begin
              shift <= mem[rd_ptr];
              tx_q  <= 1'b0;
              state <= START;
            end else begin
              tx_q  <= 1'b1;
              state <= IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt + BCNT_ONE;
          end
        end
        default: begin
          tx_q  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx   = tx_q;
  assign bus.full = full_q;
  assign bus.busy = (state != IDLE) | fifo_nempty;

endmodule

// File: tb/tb_serial_tx.sv
// Testbench for serial_tx: frame-timer reference model checked every clock, plus a line decoder.
// Latency: model predicts tx/busy/full one delta after each rising edge.
// Backpressure: model drops writes whenever DEPTH bytes are waiting.
module tb_serial_tx;

  localparam int CLKRATE  = 8;
  localparam int BAUDRATE = 1;
  localparam int DEPTH    = 4;
  localparam int DIV      = CLKRATE / BAUDRATE;
  localparam int FRAME    = 10 * DIV;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  serial_tx_if bus();

  serial_tx #(
    .CLKRATE (CLKRATE),
    .BAUDRATE(BAUDRATE),
    .DEPTH   (DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Bytes waiting, clocks left in the frame on the wire, the byte on the wire, all accepted bytes.
  logic [7:0] m_q[$];
  int         m_rem = 0;
  logic [7:0] m_cur = 8'h00;
  logic [7:0] m_acc[$];

  task automatic model_reset();
    m_q.delete();
    m_rem = 0;
    m_cur = 8'h00;
  endtask

  // Line level implied by position within the current frame.
  function automatic logic m_tx();
    int pos;
    int b;
    if (m_rem == 0) return 1'b1;
    pos = FRAME - m_rem;
    b   = pos / DIV;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_cur[b-1];
    return 1'b1;
  endfunction

  // One clock: drive inputs, step model at the edge, compare just after it.
  task automatic cycle(input logic w, input logic [7:0] d);
    bit do_pop;
    bit do_push;
    bus.wr_en   = w;
    bus.wr_data = d;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      do_pop  = (m_q.size() > 0) && (m_rem <= 1);
      do_push = w && (m_q.size() < DEPTH);
      if (do_pop) begin
        m_cur = m_q.pop_front();
        m_rem = FRAME;
      end else if (m_rem > 0) begin
        m_rem--;
      end
      if (do_push) begin
        m_q.push_back(d);
        m_acc.push_back(d);
      end
    end
    #1;
    check("tx", bus.tx, m_tx());
    check("busy", bus.busy, (m_rem > 0) || (m_q.size() > 0));
    check("full", bus.full, m_q.size() == DEPTH);
  endtask

  // Idle clocks until busy drops or the budget runs out.
  task automatic drain(input int max, output int n, output bit full_seen);
    n = 0;
    full_seen = 0;
    while (bus.busy && n < max) begin
      cycle(1'b0, 8'h00);
      n++;
      if (bus.full) full_seen = 1;
    end
    check("drain_done", bus.busy, 1'b0);
  endtask

  // ---------------- line decoder ----------------
  logic [7:0] rx_q[$];
  bit         mon_act = 0;
  int         mon_pos = 0;
  logic [7:0] mon_byte = 8'h00;

  // Samples tx mid-bit on the falling edge, starting at a falling line.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_act = 0;
    end else if (!mon_act) begin
      if (bus.tx == 1'b0) begin
        mon_act = 1;
        mon_pos = 0;
      end
    end else begin
      mon_pos++;
      if (mon_pos == DIV / 2) begin
        check("start_mid", bus.tx, 1'b0);
      end else if (mon_pos == 9 * DIV + DIV / 2) begin
        check("stop_mid", bus.tx, 1'b1);
        rx_q.push_back(mon_byte);
        mon_act = 0;
      end else if (mon_pos > DIV && mon_pos < 9 * DIV && (mon_pos % DIV) == DIV / 2) begin
        mon_byte[mon_pos / DIV - 1] = bus.tx;
      end
    end
  end

  task automatic check_rx(input string tag, input logic [7:0] exp[$]);
    check({tag, "_count"}, rx_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), rx_q[i], exp[i]);
    end
  endtask

  // Safety net against a hung run.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit fs;
    logic [7:0] exp[$];

    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;

    // Reset held for 3 clocks, then 20 quiet clocks.
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00);
    #4 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 8'h00);
      check("rst_idle_tx", bus.tx, 1'b1);
      check("rst_idle_busy", bus.busy, 1'b0);
      check("rst_idle_full", bus.full, 1'b0);
    end

    // Single byte: busy falls 81 clocks after the accepting edge.
    rx_q.delete();
    cycle(1'b1, 8'hA5);
    check("busy_after_write", bus.busy, 1'b1);
    drain(200, n, fs);
    check("single_busy_fall", n, 81);
    exp = '{8'hA5};
    check_rx("single_rx", exp);

    // Back-to-back frames: no idle gap, full never seen.
    rx_q.delete();
    cycle(1'b1, 8'h00);
    cycle(1'b1, 8'hFF);
    cycle(1'b1, 8'h3C);
    check("b2b_full", bus.full, 1'b0);
    drain(400, n, fs);
    check("b2b_busy_fall", n, 3 * FRAME + 1 - 2);
    check("b2b_full_seen", fs, 1'b0);
    exp = '{8'h00, 8'hFF, 8'h3C};
    check_rx("b2b_rx", exp);

    // Overflow: 5th write fills the FIFO, 6th is dropped.
    rx_q.delete();
    for (int i = 1; i <= 6; i++) begin
      cycle(1'b1, 8'(i));
      if (i == 4) check("ovf_full_after_4", bus.full, 1'b0);
      if (i == 5) check("ovf_full_after_5", bus.full, 1'b1);
    end
    check("ovf_full_after_6", bus.full, 1'b1);
    drain(600, n, fs);
    exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    check_rx("ovf_rx", exp);

    // Random writes with frequent overflow, checked against the model's accepted stream.
    rx_q.delete();
    m_acc.delete();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 11) == 0, 8'($urandom));
    end
    drain(1000, n, fs);
    check_rx("rand_rx", m_acc);

    // Reset in the middle of data bit 3 with two bytes queued.
    rx_q.delete();
    cycle(1'b1, 8'h55);
    cycle(1'b1, 8'hAA);
    cycle(1'b1, 8'h0F);
    for (int i = 0; i < 33; i++) cycle(1'b0, 8'h00);
    check("mid_busy_before", bus.busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_tx", bus.tx, 1'b1);
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_full", bus.full, 1'b0);
    model_reset();
    cycle(1'b0, 8'h00);
    cycle(1'b0, 8'h00);
    #4 rst_n = 1'b1;
    for (int i = 0; i < 200; i++) cycle(1'b0, 8'h00);
    check("mid_rx_count", rx_q.size(), 0);
    check("mid_busy_after", bus.busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
# serial_tx

Buffered asynchronous serial transmitter: the sending end of the 8N1 serial link that the chiptune receiver decodes from its `sdi` pin. It accepts bytes from a local writer into a small FIFO and emits them as idle-high, LSB-first frames at a fixed baud rate derived from the system clock. It is used on the host/test side of the design to drive register-write streams into the chiptune receiver over a single wire.

## Interface
- `CLKRATE`, default 3_579_545: system clock frequency in Hz.
- `BAUDRATE`, default 9600: serial bit rate in bit/s.
- `DEPTH`, default 4: FIFO entries; must be a power of two and at least 2.
- `DIVISOR` (localparam) = `CLKRATE / BAUDRATE`, integer-truncated (default 372); must be at least 2.

- `clk`  in  1  system clock; one clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  write strobe; pushes `wr_data` when `full` is 0.
- `wr_data`  in  8  byte to transmit.
- `full`  out  1  FIFO holds `DEPTH` entries; writes are dropped.
- `busy`  out  1  high while a frame is in progress or the FIFO is non-empty.
- `tx`  out  1  serial output; idle high.

## Operation
- FIFO:
  - Circular buffer with read/write pointers and a count of width clog2(`DEPTH`)+1.
  - `full` = (count == `DEPTH`), registered with count.
  - A write while `full` = 1 is discarded with no state change, even if a pop happens in the same cycle.
  - A push and a pop in the same cycle leave count unchanged.
- Frame format:
  - Start bit (0), then 8 data bits LSB first, then 1 stop bit (1).
  - No parity.
  - Frame length is 10 × `DIVISOR` clocks.
- State machine (IDLE, START, DATA, STOP):
  - IDLE: `tx` = 1. If count > 0, pop the head into the shift register, clear the bit-cycle counter, and go to START.
  - START: `tx` = 0 for `DIVISOR` clocks, then go to DATA with bit index 0.
  - DATA: `tx` = shift[0]. Every `DIVISOR` clocks, shift right and increment the bit index. After bit 7 completes, go to STOP.
  - STOP: `tx` = 1 for `DIVISOR` clocks. On the last stop cycle:
    - If count > 0, pop the head and go directly to START, so back-to-back frames have no idle gap.
    - Otherwise go to IDLE.
- Bit-cycle counter: counts 0..`DIVISOR`-1 and wraps to 0 at every bit boundary.
- `tx` is driven from a register; there is no combinational path from inputs to `tx`.
- `busy` = (state != IDLE) | (count != 0).

## Timing
- Reset (asynchronous assert, release on the next `clk` edge):
  - `tx` = 1, `full` = 0, `busy` = 0.
  - FIFO empty, state IDLE, all counters 0.
- Reset during a frame: `tx` returns to 1 immediately, the frame is truncated, and FIFO contents are lost.
- Write latency: `wr_en` sampled at edge N sets count, so `busy` = 1 after edge N.
- Start latency into an idle, empty transmitter: `tx` falls after edge N+1, i.e. 1 clock after the write is accepted.
- Each bit holds for exactly `DIVISOR` clocks with no jitter.
- Back-to-back frames: the next start bit begins on the clock immediately after the last stop-bit clock.
- `busy` falls on the edge that ends the final stop bit when the FIFO is empty.
- `full` asserts on the edge that accepts the `DEPTH`-th outstanding entry. It deasserts on the edge of the next pop.
- The byte being shifted out does not occupy a FIFO slot, so up to `DEPTH`+1 bytes are outstanding.

## Test plan
Unless stated otherwise, the bench uses `CLKRATE` = 8 and `BAUDRATE` = 1, giving `DIVISOR` = 8.

- Reset check: hold `rst_n` = 0 for 3 clocks, release, run 20 clocks with `wr_en` = 0 → `tx` = 1, `busy` = 0, `full` = 0 throughout.
- Single byte: write 0xA5 at edge N → `tx` = 0 over edges N+1..N+8, then bits 1,0,1,0,0,1,0,1 for 8 clocks each, then stop = 1. `busy` drops 81 clocks after N.
- Back-to-back: write 0x00, 0xFF, 0x3C on consecutive clocks → three frames with no idle clock between stop and start. Frames decode as 0x00, 0xFF, 0x3C. `full` never asserts.
- Overflow: write 6 bytes 0x01..0x06 on consecutive clocks → `full` = 1 after the 5th write. The 6th write is dropped and only 0x01..0x05 are transmitted.
- Reset mid-frame: assert `rst_n` = 0 asynchronously during the DATA bit 3 of 0x55, with 2 bytes queued → `tx` = 1 and `busy` = 0 immediately. No further frames after release.
- Loopback: connect `tx` to the existing `clk_gen` + chiptune receiver at default parameters. Send a register-write sequence → the receiver decodes identical bytes and the DAC output changes accordingly.
